// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   One requester's word-access channel into the memory arbiter.
//   Each transaction is a single-word read or write using a req/ack handshake.
//   The requester holds req, we, addr and wdata steady until it sees ack.
//   Ports (signals):
//     req    requester -> arbiter  request, held until ack is seen
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  word address (AW bits)
//     wdata  requester -> arbiter  write data (DW bits)
//     ack    arbiter -> requester  one-cycle completion pulse
//     rdata  arbiter -> requester  read data, valid while ack = 1
//   Modports: master = requester side, slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between two requesters.
//   p0 is the multi-cycle core and p1 is the debug/DMA loader.
//   Ties are broken round-robin, and transactions are served strictly one
//   at a time, so no request is ever reordered.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     p0, p1     requester channels (mem_port_arbiter_if.slave)
//     mem_en     one-cycle access strobe per transaction
//     mem_wen    write enable, only ever high together with mem_en
//     mem_addr   memory word address; holds its last value between accesses
//     mem_wdata  memory write data; holds its last value between accesses
//     mem_rdata  memory read data, valid RD_LAT cycles after mem_en
//     busy       high whenever the arbiter is not idle
//   Parameters: AW address width, DW data width, RD_LAT read latency (1..7).
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave p0,
  mem_port_arbiter_if.slave p1,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  logic          lat_we;
  logic [2:0]    cnt;
  logic [1:0]    ack;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  logic          grant;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // On a tie the port that did not own the previous transaction wins.
  always_comb begin
    grant     = (p0.req && p1.req) ? ~last_owner : p1.req;
    sel_we    = grant ? p1.we    : p0.we;
    sel_addr  = grant ? p1.addr  : p0.addr;
    sel_wdata = grant ? p1.wdata : p0.wdata;
  end

  // mem_addr/mem_wdata are loaded once at grant time and double as the
  // transaction latches, so the memory sees only registered values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      cnt        <= 3'd0;
      ack        <= 2'b00;
      mem_en     <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack     <= 2'b00;
      mem_en  <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (p0.req || p1.req) begin
            owner     <= grant;
            lat_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_wen   <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            ack[owner] <= 1'b1;
            state      <= RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (owner) rdata1 <= mem_rdata;
            else       rdata0 <= mem_rdata;
            ack[owner] <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          last_owner <= owner;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign p0.ack   = ack[0];
  assign p1.ack   = ack[1];
  assign p0.rdata = rdata0;
  assign p1.rdata = rdata1;

endmodule
